mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mips_pkg.sv | 33 +++
 rtl/load_ext.sv | 28 ++
 rtl/mem_wb_stage.sv | 69 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct definitions, used by the controller and the
// pipeline stages.
package mips_pkg;

   localparam logic [5:0] SPECIAL = 6'b000000;
   localparam logic [5:0] JAL     = 6'b000011;
   localparam logic [5:0] LB      = 6'b100000;
   localparam logic [5:0] LH      = 6'b100001;
   localparam logic [5:0] LW      = 6'b100011;
   localparam logic [5:0] LBU     = 6'b100100;
   localparam logic [5:0] LHU     = 6'b100101;

   // funct field under SPECIAL
   localparam logic [5:0] JALR    = 6'b001001;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] alu_out;
      logic [31:0] dm;
      logic [4:0]  a3;
      logic [31:0] pc8;
      logic        valid;
   } mw_fields_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == LW) || (op == LB) || (op == LBU) || (op == LH) || (op == LHU);
   endfunction

   function automatic logic is_link(input logic [5:0] op, input logic [5:0] funct);
      return (op == JAL) || ((op == SPECIAL) && (funct == JALR));
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extender: picks the byte/half addressed by addr and sign- or
// zero-extends it according to the load opcode; lw and non-loads pass word.
module load_ext
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [5:0]  opcode,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr, 3'b000} +: 8];
      half_sel = word[{addr[1], 4'b0000} +: 16];
      ext_data = word;
      case (opcode)
         LB:      ext_data = {{24{byte_sel[7]}}, byte_sel};
         LBU:     ext_data = {24'h000000, byte_sel};
         LH:      ext_data = {{16{half_sel[15]}}, half_sel};
         LHU:     ext_data = {16'h0000, half_sel};
         default: ext_data = word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data selection and a counter of
// instructions that actually leave the WB stage.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_W,
   input  logic             flush_W,
   input  logic [31:0]      Instr_M,
   input  logic [31:0]      ALUout_M,
   input  logic [31:0]      DM_M,
   input  logic [4:0]       A3_M,
   input  logic [31:0]      PC8_M,
   output logic [31:0]      Instr_W,
   output logic [4:0]       A3_W,
   output logic [31:0]      WD_W,
   output logic             RegWrite_W,
   output logic [CNT_W-1:0] retired_cnt
);

   mw_fields_t       w_reg;
   logic [CNT_W-1:0] retired_cnt_reg;
   logic [31:0]      ext_data;
   logic [5:0]       opcode;
   logic [5:0]       funct;

   always_ff @(posedge clk) begin
      if (reset) begin
         w_reg           <= '0;
         retired_cnt_reg <= '0;
      end else begin
         // Count on the edge the instruction leaves W, so a held one counts once.
         if (w_reg.valid && !stall_W)
            retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
         if (flush_W)
            w_reg <= '0;
         else if (!stall_W)
            w_reg <= '{instr: Instr_M, alu_out: ALUout_M, dm: DM_M,
                       a3: A3_M, pc8: PC8_M, valid: 1'b1};
      end
   end

   assign opcode = w_reg.instr[31:26];
   assign funct  = w_reg.instr[5:0];

   load_ext u_load_ext (
      .word     (w_reg.dm),
      .addr     (w_reg.alu_out[1:0]),
      .opcode   (opcode),
      .ext_data (ext_data)
   );

   always_comb begin
      WD_W = w_reg.alu_out;
      if (is_load(opcode))
         WD_W = ext_data;
      else if (is_link(opcode, funct))
         WD_W = w_reg.pc8;
   end

   assign Instr_W     = w_reg.instr;
   assign A3_W        = w_reg.a3;
   assign RegWrite_W  = w_reg.valid && (w_reg.a3 != 5'd0);
   assign retired_cnt = retired_cnt_reg;

endmodule
